pattern_scan_controller: RTL and testbench

Sequences the bit-serial `sequence_detector_1011` over parallel words. Accepts a `WORD_W`-bit word on a valid/ready handshake and clears the detector. It then shifts the word MSB-first into the detector's `sequence_in`, samples `detector_out` after every bit, and returns a per-word match count (and optionally the first match position) on a second valid/ready handshake. The detector instance sits beside this block at the same hierarchy level; this block drives the detector's `sequence_in` and `reset` and reads its `detector_out`.

---
 rtl/pattern_scan_controller_if.sv | 30 +++
 rtl/pattern_scan_controller.sv | 104 ++++++++++
 tb/tb_pattern_scan_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_controller_if.sv
// Word-in / result-out handshake bundle plus the link to the neighbouring 1011 detector.
interface pattern_scan_controller_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int POS_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              det_bit;
  logic              det_reset;
  logic              det_out;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  logic              res_hit;
  logic [POS_W-1:0]  res_first_pos;

  // Controller side: takes words, drives the detector, offers results.
  modport slave (
    input  in_valid, in_word, det_out, res_ready,
    output in_ready, det_bit, det_reset, res_valid, res_count, res_hit, res_first_pos
  );

  // Environment side: word producer, result consumer and detector.
  modport master (
    output in_valid, in_word, det_out, res_ready,
    input  in_ready, det_bit, det_reset, res_valid, res_count, res_hit, res_first_pos
  );
endinterface

// File: rtl/pattern_scan_controller.sv
// Scans one word MSB-first through an external 1011 detector and reports the match count.
// Define PSC_FIRST_POS_EN to also report the bit index of the first match.
module pattern_scan_controller #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4,
  parameter int POS_W  = 3
) (
  input logic                       clock,
  input logic                       reset,
  pattern_scan_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;

  localparam logic [POS_W-1:0] LAST = POS_W'(WORD_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [POS_W-1:0]  idx;
  logic [CNT_W-1:0]  count;
  logic              hit;
  logic              accept;
  logic              sample;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SHIFT;
      SHIFT:   if (idx == LAST)  state_nxt = DRAIN;
      DRAIN:                     state_nxt = REPORT;
      REPORT:  if (bus.res_ready) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.det_reset = (state != SHIFT);
    bus.det_bit   = (state == SHIFT) ? sreg[WORD_W-1] : 1'b0;
    bus.res_valid = (state == REPORT);
  end

  // The detector output lags its input by one cycle, so bit j is judged in
  // cycle j+1; the last bit is judged in DRAIN.
  always_comb begin
    accept = (state == IDLE) && bus.in_valid;
    sample = ((state == SHIFT) && (idx != '0)) || (state == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg  <= '0;
      idx   <= '0;
      count <= '0;
      hit   <= 1'b0;
    end else if (accept) begin
      sreg  <= bus.in_word;
      idx   <= '0;
      count <= '0;
      hit   <= 1'b0;
    end else begin
      if (state == SHIFT) begin
        sreg <= {sreg[WORD_W-2:0], 1'b0};
        idx  <= idx + POS_W'(1);
      end
      if (sample && bus.det_out) begin
        count <= sat_inc(count);
        hit   <= 1'b1;
      end
    end
  end

  assign bus.res_count = count;
  assign bus.res_hit   = hit;

`ifdef PSC_FIRST_POS_EN
  logic [POS_W-1:0] sample_pos;
  logic [POS_W-1:0] first_pos;

  always_comb begin
    sample_pos = (state == DRAIN) ? LAST : idx - POS_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || accept)                 first_pos <= '0;
    else if (sample && bus.det_out && !hit) first_pos <= sample_pos;
  end

  assign bus.res_first_pos = first_pos;
`else
  assign bus.res_first_pos = '0;
`endif

endmodule

// File: tb/tb_pattern_scan_controller.sv
// Directed bench for pattern_scan_controller with a behavioural overlapping-1011 Moore detector.
module tb_pattern_scan_controller;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef PSC_FIRST_POS_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  pattern_scan_controller_if #(.WORD_W(8),  .CNT_W(4), .POS_W(3)) ifa();
  pattern_scan_controller_if #(.WORD_W(16), .CNT_W(2), .POS_W(4)) ifb();

  pattern_scan_controller #(.WORD_W(8), .CNT_W(4), .POS_W(3)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (ifa)
  );

  pattern_scan_controller #(.WORD_W(16), .CNT_W(2), .POS_W(4)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector states: 0 idle, 1 "1", 2 "10", 3 "101", 4 "1011" (output high).
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd1 : 3'd2;
      3'd2:    return b ? 3'd3 : 3'd0;
      3'd3:    return b ? 3'd4 : 3'd2;
      3'd4:    return b ? 3'd1 : 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0] da_st;
  logic [2:0] db_st;

  always @(posedge clk) begin
    da_st <= ifa.det_reset ? 3'd0 : det_next(da_st, ifa.det_bit);
    db_st <= ifb.det_reset ? 3'd0 : det_next(db_st, ifb.det_bit);
  end

  assign ifa.det_out = (da_st == 3'd4);
  assign ifb.det_out = (db_st == 3'd4);

  function automatic logic [31:0] pexp(input int p);
    return POS_EN ? 32'(p) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_a(input string tag, input logic [7:0] word, input int hold,
                       input logic [7:0] next_word, input logic [31:0] e_cnt,
                       input logic [31:0] e_hit, input logic [31:0] e_pos, input bit chk_lat);
    int         n;
    int         bad_s;
    int         bad_r;
    logic [3:0] c;
    logic       h;
    logic [2:0] p;
    n = 0;
    while (!ifa.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_rdy"}, ifa.in_ready, 1);
    ifa.in_valid = 1'b1;
    ifa.in_word  = word;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifa.in_word  = ~word;
    n = 0;
    while (!ifa.res_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_vld"}, ifa.res_valid, 1);
    if (chk_lat) chk({tag, "_lat"}, n + 1, 10);
    c = ifa.res_count;
    h = ifa.res_hit;
    p = ifa.res_first_pos;
    chk({tag, "_cnt"}, c, e_cnt);
    chk({tag, "_hit"}, h, e_hit);
    chk({tag, "_pos"}, p, e_pos);
    bad_s = 0;
    bad_r = 0;
    for (int i = 0; i < hold; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_word  = next_word;
      @(posedge clk); #1;
      if (ifa.res_count !== c || ifa.res_hit !== h || ifa.res_first_pos !== p ||
          ifa.res_valid !== 1'b1) bad_s++;
      if (ifa.in_ready !== 1'b0) bad_r++;
    end
    if (hold > 0) begin
      chk({tag, "_stable"}, bad_s, 0);
      chk({tag, "_inrdy_hold"}, bad_r, 0);
    end
    ifa.res_ready = 1'b1;
    @(posedge clk); #1;
    ifa.res_ready = 1'b0;
    chk({tag, "_ack_rdy"}, ifa.in_ready, 1);
    chk({tag, "_ack_vld"}, ifa.res_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    ifa.in_valid  = 1'b0;
    ifa.in_word   = '0;
    ifa.res_ready = 1'b0;
    ifb.in_valid  = 1'b0;
    ifb.in_word   = '0;
    ifb.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready",  ifa.in_ready, 1);
    chk("rst_det_reset", ifa.det_reset, 1);
    chk("rst_det_bit",   ifa.det_bit, 0);
    chk("rst_res_valid", ifa.res_valid, 0);
    chk("rst_count",     ifa.res_count, 0);
    chk("rst_hit",       ifa.res_hit, 0);
    chk("rst_pos",       ifa.res_first_pos, 0);

    run_a("w1011_0000", 8'b1011_0000, 0, 8'h00, 1, 1, pexp(3), 1'b1);
    run_a("w1011_0110", 8'b1011_0110, 0, 8'h00, 2, 1, pexp(3), 1'b1);
    run_a("w0000_0000", 8'b0000_0000, 0, 8'h00, 0, 0, 0, 1'b0);

    // Result held for 5 cycles while the next word is already offered.
    run_a("b2b_first",  8'b1011_0110, 5, 8'b1011_1011, 2, 1, pexp(3), 1'b0);
    run_a("b2b_second", 8'b1011_1011, 0, 8'h00, 2, 1, pexp(3), 1'b0);

    // Abort a word with reset in SHIFT cycle 4.
    n = 0;
    while (!ifa.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    ifa.in_valid = 1'b1;
    ifa.in_word  = 8'b1011_0000;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    chk("abort_first_bit",  ifa.det_bit, 1);
    chk("abort_det_active", ifa.det_reset, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready",  ifa.in_ready, 1);
    chk("abort_det_reset", ifa.det_reset, 1);
    chk("abort_det_bit",   ifa.det_bit, 0);
    chk("abort_res_valid", ifa.res_valid, 0);
    chk("abort_count",     ifa.res_count, 0);
    chk("abort_hit",       ifa.res_hit, 0);
    chk("abort_pos",       ifa.res_first_pos, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ifa.res_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    run_a("after_abort", 8'b1011_0000, 0, 8'h00, 1, 1, pexp(3), 1'b0);

    run_a("w0000_1011", 8'b0000_1011, 0, 8'h00, 1, 1, pexp(7), 1'b0);

    // 16-bit word with five overlapping matches into a 2-bit saturating count.
    n = 0;
    while (!ifb.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("w16_rdy", ifb.in_ready, 1);
    ifb.in_valid = 1'b1;
    ifb.in_word  = 16'hB6DB;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    ifb.in_word  = 16'h0000;
    n = 0;
    while (!ifb.res_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("w16_vld", ifb.res_valid, 1);
    chk("w16_lat", n + 1, 18);
    chk("w16_cnt", ifb.res_count, 3);
    chk("w16_hit", ifb.res_hit, 1);
    chk("w16_pos", ifb.res_first_pos, pexp(3));
    ifb.res_ready = 1'b1;
    @(posedge clk); #1;
    ifb.res_ready = 1'b0;
    chk("w16_ack_rdy", ifb.in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
